// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, multi-cycle results queue in a FIFO.
// Optional feature: define WB_BYPASS_EN to let an mc result skip the empty FIFO when the slot is idle.
module wb_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_wreg,
    input  logic [31:0]              pipe_wdata,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [4:0]               mc_wreg,
    input  logic [31:0]              mc_wdata,
    output logic                     RegWrite,
    output logic [4:0]               Write_register,
    output logic [31:0]              Write_data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]       q_reg  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_live, live_nxt;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;

    logic        pipe_valid, accept, push, pop, bypass;
    logic        head_live, head_dead;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;

    assign mc_ready   = (count != (AW+1)'(DEPTH));
    assign fifo_count = count;
    assign pipe_valid = pipe_we && (pipe_wreg != 5'd0);
    assign accept     = mc_valid && mc_ready;
    assign head_live  = (count != '0) && q_live[rd_ptr];
    assign head_dead  = (count != '0) && !q_live[rd_ptr];

`ifdef WB_BYPASS_EN
    assign bypass = accept && (mc_wreg != 5'd0) && (count == '0) && !pipe_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && (mc_wreg != 5'd0) && !bypass;
    // A dead head is discarded whether or not the pipe owns the slot.
    assign pop  = head_dead || (head_live && !pipe_valid);

    always_comb begin
        wr_en   = 1'b0;
        wr_reg  = Write_register;
        wr_data = Write_data;
        if (pipe_valid) begin
            wr_en   = 1'b1;
            wr_reg  = pipe_wreg;
            wr_data = pipe_wdata;
        end else if (head_live) begin
            wr_en   = 1'b1;
            wr_reg  = q_reg[rd_ptr];
            wr_data = q_data[rd_ptr];
        end else if (bypass) begin
            wr_en   = 1'b1;
            wr_reg  = mc_wreg;
            wr_data = mc_wdata;
        end
    end

    // Squash before push so a same-cycle mc accept to the same register stays live.
    always_comb begin
        live_nxt = q_live;
        if (pop) live_nxt[rd_ptr] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_valid && q_live[i] && (q_reg[i] == pipe_wreg)) live_nxt[i] = 1'b0;
        end
        if (push) live_nxt[wr_ptr] = 1'b1;
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i]) pending[q_reg[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_live         <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            RegWrite       <= 1'b0;
            Write_register <= 5'd0;
            Write_data     <= 32'd0;
        end else begin
            q_live   <= live_nxt;
            RegWrite <= wr_en;
            if (wr_en) begin
                Write_register <= wr_reg;
                Write_data     <= wr_data;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; the live bits alone decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= mc_wreg;
            q_data[wr_ptr] <= mc_wdata;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter; honours WB_BYPASS_EN for the bypass case.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_wreg = '0;
    logic [31:0] pipe_wdata = '0;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_wreg = '0;
    logic [31:0] mc_wdata = '0;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;

    wb_write_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wreg(mc_wreg), .mc_wdata(mc_wdata),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] preg, input logic [31:0] pdata,
                         input logic mv, input logic [4:0] mreg, input logic [31:0] mdata);
        pipe_we = pwe; pipe_wreg = preg; pipe_wdata = pdata;
        mc_valid = mv; mc_wreg = mreg; mc_wdata = mdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, ".we"}, {31'd0, RegWrite}, {31'd0, we});
        check({tag, ".reg"}, {27'd0, Write_register}, {27'd0, r});
        check({tag, ".data"}, Write_data, d);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.we", {31'd0, RegWrite}, 32'd0);
        check("rst.reg", {27'd0, Write_register}, 32'd0);
        check("rst.data", Write_data, 32'd0);
        check("rst.pending", pending, 32'd0);
        check("rst.count", {29'd0, fifo_count}, 32'd0);
        check("rst.ready", {31'd0, mc_ready}, 32'd1);
        #6 reset = 1'b1;

        // Fill while the pipe holds the port
        drive(1, 5'd31, 32'hF0, 1, 5'd1, 32'h11);
        tick();
        expect_wr("fill.e1", 1, 5'd31, 32'hF0);
        check("fill.e1.count", {29'd0, fifo_count}, 32'd1);
        check("fill.e1.pending", pending, 32'h2);
        drive(1, 5'd31, 32'hF0, 1, 5'd2, 32'h22); tick();
        drive(1, 5'd31, 32'hF0, 1, 5'd3, 32'h33); tick();
        drive(1, 5'd31, 32'hF0, 1, 5'd4, 32'h44); tick();
        check("fill.e4.count", {29'd0, fifo_count}, 32'd4);
        check("fill.e4.ready", {31'd0, mc_ready}, 32'd0);
        check("fill.e4.pending", pending, 32'h1E);
        drive(1, 5'd31, 32'hF0, 1, 5'd5, 32'h55); tick();
        check("fill.e5.count", {29'd0, fifo_count}, 32'd4);
        check("fill.e5.ready", {31'd0, mc_ready}, 32'd0);

        // Pipe drops: no pass-through while full, then the 5th enters
        drive(0, 5'd0, 32'h0, 1, 5'd5, 32'h55); tick();
        expect_wr("drain1", 1, 5'd1, 32'h11);
        check("drain1.count", {29'd0, fifo_count}, 32'd3);
        check("drain1.ready", {31'd0, mc_ready}, 32'd1);
        tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expect_wr("drain2", 1, 5'd2, 32'h22);
        check("drain2.count", {29'd0, fifo_count}, 32'd3);
        check("drain2.pending", pending, 32'h38);
        tick(); expect_wr("drain3", 1, 5'd3, 32'h33);
        tick(); expect_wr("drain4", 1, 5'd4, 32'h44);
        check("drain4.pending", pending, 32'h20);
        tick(); expect_wr("drain5", 1, 5'd5, 32'h55);
        check("drain5.count", {29'd0, fifo_count}, 32'd0);
        check("drain5.pending", pending, 32'h0);
        tick(); expect_wr("idle", 0, 5'd5, 32'h55);

        // Priority: pipe first, queued mc next edge
        drive(1, 5'd9, 32'hBBBB, 1, 5'd8, 32'hAAAA); tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expect_wr("prio.pipe", 1, 5'd9, 32'hBBBB);
        check("prio.pending", pending, 32'h100);
        tick(); expect_wr("prio.mc", 1, 5'd8, 32'hAAAA);
        check("prio.count", {29'd0, fifo_count}, 32'd0);

        // WAW squash
        drive(0, 5'd0, 32'h0, 1, 5'd7, 32'h1234); tick();
        drive(1, 5'd7, 32'h5678, 0, 5'd0, 32'h0);
        check("sq.queued.we", {31'd0, RegWrite}, 32'd0);
        check("sq.queued.pending", pending, 32'h80);
        tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expect_wr("sq.pipe", 1, 5'd7, 32'h5678);
        check("sq.pending", pending, 32'h0);
        check("sq.dead.count", {29'd0, fifo_count}, 32'd1);
        tick(); expect_wr("sq.deadpop", 0, 5'd7, 32'h5678);
        check("sq.deadpop.count", {29'd0, fifo_count}, 32'd0);

        // Live entry behind a dead head; same-cycle younger mc stays live
        drive(0, 5'd0, 32'h0, 1, 5'd6, 32'h1); tick();
        drive(1, 5'd6, 32'h66, 1, 5'd4, 32'h44); tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        expect_wr("dh.pipe", 1, 5'd6, 32'h66);
        check("dh.pending", pending, 32'h10);
        check("dh.count", {29'd0, fifo_count}, 32'd2);
        tick(); expect_wr("dh.deadpop", 0, 5'd6, 32'h66);
        check("dh.deadpop.count", {29'd0, fifo_count}, 32'd1);
        tick(); expect_wr("dh.live", 1, 5'd4, 32'h44);
        check("dh.live.count", {29'd0, fifo_count}, 32'd0);

        // Register 0 on both sources
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD);
        check("r0.ready", {31'd0, mc_ready}, 32'd1);
        tick();
        check("r0.mc.count", {29'd0, fifo_count}, 32'd0);
        check("r0.mc.we", {31'd0, RegWrite}, 32'd0);
        drive(1, 5'd0, 32'hBEEF, 0, 5'd0, 32'h0); tick();
        expect_wr("r0.pipe", 0, 5'd4, 32'h44);

        // Bypass / FIFO latency
        drive(0, 5'd0, 32'h0, 1, 5'd3, 32'hCAFE); tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
        expect_wr("byp.accept", 1, 5'd3, 32'hCAFE);
        check("byp.accept.pending", pending, 32'h0);
        check("byp.accept.count", {29'd0, fifo_count}, 32'd0);
        tick(); expect_wr("byp.next", 0, 5'd3, 32'hCAFE);
`else
        expect_wr("byp.accept", 0, 5'd4, 32'h44);
        check("byp.accept.pending", pending, 32'h8);
        check("byp.accept.count", {29'd0, fifo_count}, 32'd1);
        tick(); expect_wr("byp.next", 1, 5'd3, 32'hCAFE);
        check("byp.next.pending", pending, 32'h0);
`endif

        // Asynchronous reset with three entries queued
        drive(1, 5'd31, 32'h0, 1, 5'd10, 32'hA); tick();
        drive(1, 5'd31, 32'h0, 1, 5'd11, 32'hB); tick();
        drive(1, 5'd31, 32'h0, 1, 5'd12, 32'hC); tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        check("pre.count", {29'd0, fifo_count}, 32'd3);
        check("pre.we", {31'd0, RegWrite}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("arst.count", {29'd0, fifo_count}, 32'd0);
        check("arst.pending", pending, 32'h0);
        check("arst.we", {31'd0, RegWrite}, 32'd0);
        check("arst.ready", {31'd0, mc_ready}, 32'd1);
        #4 reset = 1'b1;
        tick();
        check("post.we", {31'd0, RegWrite}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
